// File: rtl/d_sram_bridge_pkg.sv
// rtl/d_sram_bridge_pkg.sv - shared types and constants for the data-side SRAM bridge
// Contents: FSM state encoding, bus size codes, kseg mask, size normalisation helper.
package d_sram_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0]  SIZE_BYTE = 2'd0;
    localparam logic [1:0]  SIZE_HALF = 2'd1;
    localparam logic [1:0]  SIZE_WORD = 2'd2;

    localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

    // Code 3 is not a legal access size; it is presented to the bus as a word.
    function automatic logic [1:0] norm_size(input logic [1:0] s);
        return ((s == SIZE_BYTE) || (s == SIZE_HALF)) ? s : SIZE_WORD;
    endfunction

endpackage

// File: rtl/d_sram_bridge_addr_map.sv
// rtl/d_sram_bridge_addr_map.sv - fixed virtual-to-physical address map (kseg0/kseg1)
// Build option: D_SRAM_BRIDGE_ADDR_MAP_EN maps kseg0/kseg1 via KSEG_MASK; otherwise pass-through.
// Ports:
//   vaddr  in   ADDR_W  virtual address
//   paddr  out  ADDR_W  physical address
module d_sram_bridge_addr_map
    import d_sram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] vaddr,
    output logic [ADDR_W-1:0] paddr
);

`ifdef D_SRAM_BRIDGE_ADDR_MAP_EN
    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(KSEG_MASK);

    // Top bits 100 (kseg0) or 101 (kseg1) both start with 10.
    always_comb begin
        if (vaddr[ADDR_W-1 -: 2] == 2'b10) begin
            paddr = vaddr & MASK;
        end else begin
            paddr = vaddr;
        end
    end
`else
    assign paddr = vaddr;
`endif

endmodule

// File: rtl/d_sram_bridge.sv
// rtl/d_sram_bridge.sv - MEM-stage to SRAM-like split-handshake data bus bridge
// Build option: D_SRAM_BRIDGE_ADDR_MAP_EN enables kseg0/kseg1 address mapping.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mem_en/mem_we/mem_sel    MEM-stage access valid, store flag, byte strobes
//   mem_size/mem_addr        access size code, effective address
//   mem_wdata                lane-aligned store data
//   mem_cancel               MEM-stage exception/flush
//   longest_stall            pipeline held by another source
//   mem_rdata                load data to MEM stage
//   stallreq_from_mem        pipeline hold request
//   data_req/data_wr/...     bus request side (req, wr, size, addr, wdata, wstrb)
//   data_addr_ok/data_data_ok/data_rdata  bus response side
module d_sram_bridge
    import d_sram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_en,
    input  logic                  mem_we,
    input  logic [DATA_W/8-1:0]   mem_sel,
    input  logic [1:0]            mem_size,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_cancel,
    input  logic                  longest_stall,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  stallreq_from_mem,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_W-1:0]     data_addr,
    output logic [DATA_W-1:0]     data_wdata,
    output logic [DATA_W/8-1:0]   data_wstrb,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [DATA_W-1:0]     data_rdata
);

    state_t                state_q;
    state_t                state_d;

    logic                  wr_q;
    logic [1:0]            size_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  killed_q;

    logic [ADDR_W-1:0]     phys_addr;
    logic                  issue;
    logic                  complete;
    logic                  capture;
    logic                  in_flight;
    logic                  kill_now;

    d_sram_bridge_addr_map #(
        .ADDR_W (ADDR_W)
    ) u_addr_map (
        .vaddr (mem_addr),
        .paddr (phys_addr)
    );

    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign data_wstrb = wstrb_q;

    assign in_flight = (state_q == ST_REQ) || (state_q == ST_WAIT);
    // A cancel arriving in the completion cycle itself must also discard the response.
    assign kill_now  = killed_q | mem_cancel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        data_req          = 1'b0;
        stallreq_from_mem = 1'b0;
        issue             = 1'b0;
        complete          = 1'b0;
        capture           = 1'b0;
        mem_rdata         = rdata_q;

        case (state_q)
            ST_IDLE: begin
                issue             = mem_en & ~mem_cancel;
                stallreq_from_mem = issue;
                if (issue) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Request stays up until accepted, even if the access was cancelled.
                data_req          = 1'b1;
                stallreq_from_mem = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        complete = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stallreq_from_mem = 1'b1;
                if (data_data_ok) begin
                    complete = 1'b1;
                end
            end
            ST_DONE: begin
                if (!longest_stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (complete) begin
            // A dead transaction still holds a newly arrived access until the bus is free.
            stallreq_from_mem = killed_q & mem_en;
            capture           = ~kill_now;
            mem_rdata         = data_rdata;
            // DONE only parks a live result; a discarded one goes straight back to IDLE.
            state_d           = (capture && longest_stall) ? ST_DONE : ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q     <= 1'b0;
            size_q   <= SIZE_BYTE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            killed_q <= 1'b0;
        end else begin
            if (issue) begin
                wr_q    <= mem_we;
                size_q  <= norm_size(mem_size);
                addr_q  <= phys_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_we ? mem_sel : '0;
            end
            if (capture) begin
                rdata_q <= data_rdata;
            end
            if (complete) begin
                killed_q <= 1'b0;
            end else if (in_flight && mem_cancel) begin
                killed_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_d_sram_bridge.sv
// tb/tb_d_sram_bridge.sv - scoreboard testbench for d_sram_bridge
module tb_d_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_cancel;
    logic        longest_stall;
    logic [31:0] mem_rdata;
    logic        stallreq;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

`ifdef D_SRAM_BRIDGE_ADDR_MAP_EN
    localparam logic [31:0] T1_EXP_ADDR = 32'h0000_1000;
`else
    localparam logic [31:0] T1_EXP_ADDR = 32'h8000_1000;
`endif

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        logic        is_load;
        logic [31:0] rdata;
    } ret_t;

    req_t req_q[$];
    ret_t ret_q[$];
    req_t mon_req;
    ret_t mon_ret;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    d_sram_bridge dut (
        .clk               (clk),
        .rst               (rst),
        .mem_en            (mem_en),
        .mem_we            (mem_we),
        .mem_sel           (mem_sel),
        .mem_size          (mem_size),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_cancel        (mem_cancel),
        .longest_stall     (longest_stall),
        .mem_rdata         (mem_rdata),
        .stallreq_from_mem (stallreq),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_wstrb        (data_wstrb),
        .data_addr_ok      (data_addr_ok),
        .data_data_ok      (data_data_ok),
        .data_rdata        (data_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [3:0] sel, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        mem_en    = 1'b1;
        mem_we    = we;
        mem_sel   = sel;
        mem_size  = size;
        mem_addr  = addr;
        mem_wdata = wdata;
    endtask

    task automatic push_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        req_t r;
        r.wr = wr; r.size = size; r.addr = addr; r.wdata = wdata; r.wstrb = wstrb;
        req_q.push_back(r);
    endtask

    task automatic push_ret(input logic is_load, input logic [31:0] rdata);
        ret_t r;
        r.is_load = is_load; r.rdata = rdata;
        ret_q.push_back(r);
    endtask

    task automatic quiet();
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_cancel    = 1'b0;
        longest_stall = 1'b0;
        data_addr_ok  = 1'b0;
        data_data_ok  = 1'b0;
    endtask

    // Bus-side monitor: each accepted request must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && data_req && data_addr_ok) begin
            if (req_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL req_unexpected: got request addr %h, expected none", data_addr);
            end else begin
                mon_req = req_q.pop_front();
                check("req_wr",    32'(data_wr),    32'(mon_req.wr));
                check("req_size",  32'(data_size),  32'(mon_req.size));
                check("req_addr",  data_addr,       mon_req.addr);
                check("req_wdata", data_wdata,      mon_req.wdata);
                check("req_wstrb", 32'(data_wstrb), 32'(mon_req.wstrb));
            end
        end
    end

    // Pipeline-side monitor: an access retires when the MEM stage is free to advance.
    always @(negedge clk) begin
        if (!rst && mem_en && !stallreq && !longest_stall && !mem_cancel) begin
            if (ret_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL ret_unexpected: got retire with rdata %h, expected none", mem_rdata);
            end else begin
                mon_ret = ret_q.pop_front();
                check("ret_wr", 32'(data_wr), 32'(!mon_ret.is_load));
                if (mon_ret.is_load) begin
                    check("ret_rdata", mem_rdata, mon_ret.rdata);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        quiet();
        mem_sel = 4'h0; mem_size = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0; data_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        neg();
        check("rst_req",   32'(data_req),   32'h0);
        check("rst_wr",    32'(data_wr),    32'h0);
        check("rst_size",  32'(data_size),  32'h0);
        check("rst_addr",  data_addr,       32'h0);
        check("rst_wdata", data_wdata,      32'h0);
        check("rst_wstrb", 32'(data_wstrb), 32'h0);
        check("rst_stall", 32'(stallreq),   32'h0);
        check("rst_rdata", mem_rdata,       32'h0);

        // Word load, kseg0 address, addr_ok at cycle 2, data_ok at cycle 4.
        cyc();
        issue(1'b0, 4'hF, 2'd2, 32'h8000_1000, 32'h0);
        push_req(1'b0, 2'd2, T1_EXP_ADDR, 32'h0, 4'h0);
        push_ret(1'b1, 32'hDEAD_BEEF);
        neg(); check("t1_stall_c0", 32'(stallreq), 32'h1); check("t1_req_c0", 32'(data_req), 32'h0);
        cyc(); neg(); check("t1_stall_c1", 32'(stallreq), 32'h1); check("t1_req_c1", 32'(data_req), 32'h1);
        cyc(); data_addr_ok = 1'b1;
        neg(); check("t1_stall_c2", 32'(stallreq), 32'h1);
        cyc(); data_addr_ok = 1'b0;
        neg(); check("t1_stall_c3", 32'(stallreq), 32'h1); check("t1_req_c3", 32'(data_req), 32'h0);
        cyc(); data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        neg(); check("t1_stall_c4", 32'(stallreq), 32'h0); check("t1_rdata_c4", mem_rdata, 32'hDEAD_BEEF);
        cyc(); quiet();
        neg(); check("t1_req_after", 32'(data_req), 32'h0);

        // Byte store held off by three cycles of addr_ok = 0; MEM inputs disturbed meanwhile.
        cyc();
        issue(1'b1, 4'b0100, 2'd0, 32'h0000_0002, 32'h00AB_0000);
        push_req(1'b1, 2'd0, 32'h0000_0002, 32'h00AB_0000, 4'b0100);
        push_ret(1'b0, 32'h0);
        neg(); check("t2_stall_c0", 32'(stallreq), 32'h1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            mem_addr = 32'hFFFF_FFF0; mem_wdata = 32'h1212_1212; mem_sel = 4'hF; mem_size = 2'd2;
            neg();
            check("t2_req_held", 32'(data_req),   32'h1);
            check("t2_wr",       32'(data_wr),    32'h1);
            check("t2_wstrb",    32'(data_wstrb), 32'h4);
            check("t2_size",     32'(data_size),  32'h0);
            check("t2_addr",     data_addr,       32'h0000_0002);
            check("t2_wdata",    data_wdata,      32'h00AB_0000);
        end
        cyc(); data_addr_ok = 1'b1;
        neg();
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1;
        neg(); check("t2_stall_done", 32'(stallreq), 32'h0);
        cyc(); quiet();

        // Load accepted and answered in the same cycle.
        issue(1'b0, 4'hF, 2'd2, 32'h0000_0040, 32'h0);
        push_req(1'b0, 2'd2, 32'h0000_0040, 32'h0, 4'h0);
        push_ret(1'b1, 32'h1234_5678);
        neg();
        cyc(); data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        neg(); check("t3_stall", 32'(stallreq), 32'h0); check("t3_rdata", mem_rdata, 32'h1234_5678);
        cyc(); quiet();
        for (int i = 0; i < 2; i++) begin
            neg(); check("t3_no_second_req", 32'(data_req), 32'h0);
            cyc();
        end

        // Completion while another source holds the pipeline for three cycles.
        issue(1'b0, 4'hF, 2'd2, 32'h0000_0100, 32'h0);
        push_req(1'b0, 2'd2, 32'h0000_0100, 32'h0, 4'h0);
        push_ret(1'b1, 32'hCAFE_F00D);
        neg();
        cyc(); data_addr_ok = 1'b1;
        neg();
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; longest_stall = 1'b1;
        neg(); check("t4_stall_cpl", 32'(stallreq), 32'h0); check("t4_rdata_cpl", mem_rdata, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            cyc(); data_data_ok = 1'b0; data_rdata = 32'h0BAD_BAD0;
            neg();
            check("t4_done_stall", 32'(stallreq), 32'h0);
            check("t4_done_req",   32'(data_req), 32'h0);
            check("t4_done_rdata", mem_rdata,     32'hCAFE_F00D);
        end
        cyc(); longest_stall = 1'b0;
        neg(); check("t4_release_stall", 32'(stallreq), 32'h0);
        cyc(); quiet();
        neg(); check("t4_idle_req", 32'(data_req), 32'h0); check("t4_idle_stall", 32'(stallreq), 32'h0);

        // Cancel in WAIT; the next access waits for the dead transaction.
        cyc();
        issue(1'b0, 4'hF, 2'd2, 32'h0000_0200, 32'h0);
        push_req(1'b0, 2'd2, 32'h0000_0200, 32'h0, 4'h0);
        neg();
        cyc(); data_addr_ok = 1'b1;
        neg();
        cyc(); data_addr_ok = 1'b0; mem_cancel = 1'b1;
        neg(); check("t5_stall_cancel", 32'(stallreq), 32'h1);
        cyc(); mem_cancel = 1'b0;
        issue(1'b0, 4'hF, 2'd2, 32'h0000_0300, 32'h0);
        push_req(1'b0, 2'd2, 32'h0000_0300, 32'h0, 4'h0);
        push_ret(1'b1, 32'h0F0F_0F0F);
        neg(); check("t5_stall_wait", 32'(stallreq), 32'h1); check("t5_req_wait", 32'(data_req), 32'h0);
        cyc(); data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
        neg(); check("t5_stall_killed_cpl", 32'(stallreq), 32'h1);
        cyc(); data_data_ok = 1'b0;
        neg();
        check("t5_rdata_kept", mem_rdata,      32'hCAFE_F00D);
        check("t5_stall_idle", 32'(stallreq),  32'h1);
        check("t5_req_idle",   32'(data_req),  32'h0);
        cyc();
        neg(); check("t5_req_new", 32'(data_req), 32'h1);
        cyc(); data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0F0F_0F0F;
        neg(); check("t5_stall_new_cpl", 32'(stallreq), 32'h0);
        cyc(); quiet();

        // Asynchronous reset while waiting for a store response.
        issue(1'b1, 4'hF, 2'd2, 32'h0000_0404, 32'h1122_3344);
        push_req(1'b1, 2'd2, 32'h0000_0404, 32'h1122_3344, 4'hF);
        neg();
        cyc(); data_addr_ok = 1'b1;
        neg();
        cyc(); data_addr_ok = 1'b0;
        check("t6_wr_before", 32'(data_wr), 32'h1);
        #2 rst = 1'b1; mem_en = 1'b0;
        #1;
        check("t6_req",   32'(data_req),   32'h0);
        check("t6_wr",    32'(data_wr),    32'h0);
        check("t6_size",  32'(data_size),  32'h0);
        check("t6_addr",  data_addr,       32'h0);
        check("t6_wdata", data_wdata,      32'h0);
        check("t6_wstrb", 32'(data_wstrb), 32'h0);
        check("t6_stall", 32'(stallreq),   32'h0);
        check("t6_rdata", mem_rdata,       32'h0);
        cyc(); rst = 1'b0;
        neg(); check("t6_req_after", 32'(data_req), 32'h0); check("t6_stall_after", 32'(stallreq), 32'h0);

        cyc();
        neg();
        check("req_q_empty", 32'(req_q.size()), 32'h0);
        check("ret_q_empty", 32'(ret_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
